// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive FIFO.
//   fetch_state_t  - states of the receiver fetch handshake
//   DEFAULT_DEPTH  - default number of FIFO entries
//   DEFAULT_WIDTH  - default data bits per entry
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } fetch_state_t;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/rx_fifo_mem.sv
// rx_fifo_mem: dual-port register array for the receive FIFO.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, combinational from the array
// The array is deliberately not reset; only the pointers around it are.
module rx_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read gives first-word fall-through at the FIFO output.
  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: fetches characters from a UART receiver and queues them.
//   Clock, Reset       - system clock, asynchronous active-high reset
//   RxRDY              - receiver character ready (baud domain, synchronized here)
//   RxData/RxParityErr - receiver character and its parity error flag
//   RD                 - read strobe / output enable back to the receiver
//   Pop                - dequeue the head entry
//   Dout/DoutParErr    - head entry (first-word fall-through)
//   Empty/Full/Count   - occupancy
//   Overrun/ClrOverrun - sticky lost-character flag and its clear
// Build option: define UART_RXFIFO_PARITY_EN to store the parity error bit
// alongside each entry; otherwise RxParityErr is ignored and DoutParErr is 0.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     RxRDY,
  input  logic [WIDTH-1:0]         RxData,
  input  logic                     RxParityErr,
  output logic                     RD,
  input  logic                     Pop,
  output logic [WIDTH-1:0]         Dout,
  output logic                     DoutParErr,
  output logic                     Empty,
  output logic                     Full,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overrun,
  input  logic                     ClrOverrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_RXFIFO_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

  logic [1:0]    sync_reg;
  logic          rx_rdy_s;
  fetch_state_t  state_reg, state_next;
  logic          capture;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overrun_reg;
  logic          do_wr, do_pop, lost;
  logic [EW-1:0] wdata, rdata;

  // Two-flop synchronizer for the baud-domain ready flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], RxRDY};
    end
  end
  assign rx_rdy_s = sync_reg[1];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // RD is decoded from the state register so reset drops it immediately.
  always_comb begin
    state_next = state_reg;
    RD         = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_rdy_s) state_next = CAPTURE;
      end
      CAPTURE: begin
        RD         = 1'b1;
        capture    = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        RD = 1'b1;
        if (!rx_rdy_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Empty = (count_reg == '0);
  assign Full  = (count_reg == CW'(DEPTH));
  assign Count = count_reg;

  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign do_pop = Pop & ~Empty;
  assign do_wr  = capture & (~Full | Pop);
  assign lost   = capture & Full & ~Pop;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_wr, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      // A new overrun takes priority over a simultaneous clear.
      if (lost) begin
        overrun_reg <= 1'b1;
      end else if (ClrOverrun) begin
        overrun_reg <= 1'b0;
      end
    end
  end
  assign Overrun = overrun_reg;

`ifdef UART_RXFIFO_PARITY_EN
  assign wdata      = {RxParityErr, RxData};
  assign Dout       = rdata[WIDTH-1:0];
  assign DoutParErr = rdata[WIDTH];
`else
  logic unused_parity;
  assign unused_parity = RxParityErr;
  assign wdata         = RxData;
  assign Dout          = rdata;
  assign DoutParErr    = 1'b0;
`endif

  rx_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk   (Clock),
    .we    (do_wr),
    .waddr (wr_ptr_reg),
    .wdata (wdata),
    .raddr (rd_ptr_reg),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized checks of uart_rx_fifo against a
// queue-based reference model. Honours UART_RXFIFO_PARITY_EN for DoutParErr.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              RxRDY;
  logic [WIDTH-1:0]  RxData;
  logic              RxParityErr;
  logic              RD;
  logic              Pop;
  logic [WIDTH-1:0]  Dout;
  logic              DoutParErr;
  logic              Empty;
  logic              Full;
  logic [3:0]        Count;
  logic              Overrun;
  logic              ClrOverrun;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {parity, data} plus the sticky overrun flag.
  logic [WIDTH:0] q[$];
  logic           m_ovr;

  always #5 Clock = ~Clock;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .RxRDY       (RxRDY),
    .RxData      (RxData),
    .RxParityErr (RxParityErr),
    .RD          (RD),
    .Pop         (Pop),
    .Dout        (Dout),
    .DoutParErr  (DoutParErr),
    .Empty       (Empty),
    .Full        (Full),
    .Count       (Count),
    .Overrun     (Overrun),
    .ClrOverrun  (ClrOverrun)
  );

  function automatic logic exp_pe(input logic pe);
`ifdef UART_RXFIFO_PARITY_EN
    return pe;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 64'(Count), 64'(q.size()));
    chk({tag, ".empty"}, 64'(Empty), 64'(q.size() == 0));
    chk({tag, ".full"}, 64'(Full), 64'(q.size() == DEPTH));
    chk({tag, ".overrun"}, 64'(Overrun), 64'(m_ovr));
    if (q.size() > 0) begin
      chk({tag, ".dout"}, 64'(Dout), 64'(q[0][WIDTH-1:0]));
      chk({tag, ".parerr"}, 64'(DoutParErr), 64'(exp_pe(q[0][WIDTH])));
    end
  endtask

  // Full fetch handshake; inputs change only on falling edges.
  task automatic send_char(input logic [WIDTH-1:0] d, input logic pe,
                           input logic pop_with, input logic clr_with);
    int k;
    bit was_full;
    RxData = d;
    RxParityErr = pe;
    RxRDY = 1'b1;
    k = 0;
    do begin
      @(negedge Clock);
      k++;
    end while (!RD && k < 10);
    chk("rd_latency", 64'(k), 64'd3);
    was_full = (q.size() == DEPTH);
    if (pop_with && q.size() > 0)
      chk("cap_pop_head", 64'(Dout), 64'(q[0][WIDTH-1:0]));
    Pop = pop_with;
    ClrOverrun = clr_with;
    @(negedge Clock);
    Pop = 1'b0;
    ClrOverrun = 1'b0;
    if (pop_with && q.size() > 0) void'(q.pop_front());
    if (!was_full || pop_with) q.push_back({pe, d});
    if (was_full && !pop_with) m_ovr = 1'b1;
    else if (clr_with) m_ovr = 1'b0;
    chk("hold_rd", 64'(RD), 64'd1);
    check_all("capture");
    RxRDY = 1'b0;
    k = 0;
    do begin
      @(negedge Clock);
      k++;
    end while (RD && k < 10);
    chk("rd_release", 64'(RD), 64'd0);
    RxData = $urandom;
    $display("char data=%08h pe=%0b pop=%0b clr=%0b count=%0d overrun=%0b",
             d, pe, pop_with, clr_with, Count, Overrun);
  endtask

  task automatic pop_one(input logic clr);
    if (q.size() > 0) chk("pop_head", 64'(Dout), 64'(q[0][WIDTH-1:0]));
    Pop = 1'b1;
    ClrOverrun = clr;
    @(negedge Clock);
    Pop = 1'b0;
    ClrOverrun = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    if (clr) m_ovr = 1'b0;
    check_all("pop");
    $display("pop clr=%0b count=%0d empty=%0b", clr, Count, Empty);
  endtask

  task automatic clr_only();
    ClrOverrun = 1'b1;
    @(negedge Clock);
    ClrOverrun = 1'b0;
    m_ovr = 1'b0;
    check_all("clr");
    $display("clear overrun=%0b", Overrun);
  endtask

  initial begin
    int k;
    Reset = 1'b1;
    RxRDY = 1'b0;
    RxData = '0;
    RxParityErr = 1'b0;
    Pop = 1'b0;
    ClrOverrun = 1'b0;
    m_ovr = 1'b0;
    repeat (3) @(negedge Clock);
    chk("reset.rd", 64'(RD), 64'd0);
    check_all("reset");
    Reset = 1'b0;
    @(negedge Clock);
    check_all("post_reset");

    // Single character, then drain.
    send_char(32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    pop_one(1'b0);

    // Pop on empty must change nothing; next write lands at the head.
    pop_one(1'b0);
    pop_one(1'b0);
    send_char(32'h12345678, 1'b0, 1'b0, 1'b0);
    pop_one(1'b0);

    // Nine characters without Pop: fill then overrun.
    for (int i = 0; i < 9; i++) send_char(32'(i), 1'b0, 1'b0, 1'b0);
    clr_only();
    // Full with coincident pop: occupancy unchanged, no overrun.
    send_char(32'hA5A5_0009, 1'b0, 1'b1, 1'b0);
    // Overrun while clearing in the same cycle: set wins.
    send_char(32'hBAD0_0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) pop_one(1'b0);
    clr_only();

    // Parity flag propagation.
    send_char(32'h55, 1'b1, 1'b0, 1'b0);
    pop_one(1'b0);

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) send_char($urandom, 1'($urandom), r == 0, r == 1);
      else if (r < 9) pop_one(r == 8);
      else clr_only();
    end

    // Reset during HOLD aborts the fetch and empties the FIFO.
    RxData = 32'hCAFEF00D;
    RxRDY = 1'b1;
    k = 0;
    do begin
      @(negedge Clock);
      k++;
    end while (!RD && k < 10);
    @(negedge Clock);
    chk("hold_before_reset.rd", 64'(RD), 64'd1);
    Reset = 1'b1;
    #1;
    chk("reset_in_hold.rd", 64'(RD), 64'd0);
    chk("reset_in_hold.count", 64'(Count), 64'd0);
    chk("reset_in_hold.empty", 64'(Empty), 64'd1);
    q.delete();
    m_ovr = 1'b0;
    RxRDY = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (4) @(negedge Clock);
    chk("after_reset.rd", 64'(RD), 64'd0);
    check_all("after_reset");
    send_char(32'h0BADCAFE, 1'b1, 1'b0, 1'b0);
    pop_one(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter WIDTH, default 32, data bits per entry; matches receiver Dout.
REQ-003 SHALL have port Clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port RxRDY  input  1  receiver character-ready flag; asynchronous to Clock (baud domain).
REQ-006 SHALL have port RxData  input  WIDTH  receiver Dout; valid only while RD is high.
REQ-007 SHALL have port RxParityErr  input  1  receiver parity-error flag for the current character.
REQ-008 SHALL have port RD  output  1  read strobe and output-enable to the receiver.
REQ-009 SHALL have port Pop  input  1  CPU-side dequeue request.
REQ-010 SHALL have port Dout  output  WIDTH  head entry data, first-word fall-through.
REQ-011 SHALL have port DoutParErr  output  1  parity-error bit of the head entry.
REQ-012 SHALL have port Empty, Full  output  1 each  FIFO occupancy flags.
REQ-013 SHALL have port Count  output  log2(DEPTH)+1  number of stored entries.
REQ-014 SHALL have port Overrun  output  1  sticky flag, set when a character is discarded.
REQ-015 SHALL have port ClrOverrun  input  1  synchronous clear of Overrun.

Function
REQ-016 SHALL pass RxRDY through a two-flop synchronizer (RxRDY_s) before any use.
REQ-017 SHALL implement a fetch FSM with states IDLE, CAPTURE and HOLD.
REQ-018 IDLE -> CAPTURE when RxRDY_s=1; RD=0 in IDLE.
REQ-019 CAPTURE: RD=1 for exactly one cycle; RxData and RxParityErr are sampled at the closing edge; next state is HOLD.
REQ-020 HOLD: RD stays 1 until RxRDY_s=0, then the FSM returns to IDLE; no further sampling occurs in HOLD.
REQ-021 Capture with the FIFO not full (or full with Pop in the same cycle) SHALL write one entry.
REQ-022 Capture with the FIFO full and no Pop SHALL discard the character and set Overrun; the fetch sequence still completes so the receiver is drained.
REQ-023 Pop with Empty=0 SHALL advance the read pointer; Pop with Empty=1 SHALL be ignored, with no change to pointers or Count.
REQ-024 Simultaneous write and pop SHALL leave Count unchanged; on an empty FIFO only the write takes effect.
REQ-025 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; Count = writes minus pops and never exceeds DEPTH.
REQ-026 Empty = (Count==0) and Full = (Count==DEPTH), both registered-consistent with Count in the same cycle.
REQ-027 Dout/DoutParErr SHALL show the head entry combinationally from storage; both are don't-care while Empty=1.
REQ-028 An entry written at edge N SHALL be visible on Dout, with Empty=0, after edge N (latency 1).
REQ-029 Latency from RxRDY rising to RD rising SHALL be 3 Clock edges.
REQ-030 ClrOverrun together with a new overrun event in the same cycle: set wins.

Reset
REQ-031 Reset SHALL force: FSM=IDLE, RD=0, synchronizer=0, pointers=0, Count=0, Empty=1, Full=0, Overrun=0.
REQ-032 Reset asserted mid-fetch SHALL abort the fetch without a write; storage contents are not cleared.

Configuration
REQ-033 Macro UART_RXFIFO_PARITY_EN defined: each entry is WIDTH+1 bits and DoutParErr reflects the stored bit.
REQ-034 Macro UART_RXFIFO_PARITY_EN undefined: entries are WIDTH bits, RxParityErr is ignored and DoutParErr is tied 0.

Structure
REQ-035 Shared package uart_pkg SHALL hold the FSM state enum (IDLE/CAPTURE/HOLD) and the default DEPTH/WIDTH constants.
REQ-036 Storage SHALL be one sub-module rx_fifo_mem: dual-port register array with synchronous write and asynchronous read, no reset on the array.

Verification
REQ-037 RxRDY pulse with RxData=32'hDEADBEEF, RxParityErr=0 -> RD high on 3rd edge; Dout=DEADBEEF, Count=1, Empty=0.
REQ-038 Nine characters 0..8 with no Pop (DEPTH=8) -> Full=1 after the 8th, Overrun=1 after the 9th; Pops return 0..7 in order.
REQ-039 Pop on an empty FIFO -> Count stays 0, Empty stays 1, pointers unchanged.
REQ-040 FIFO full, capture coincides with Pop -> Count stays 8, Overrun stays 0, new entry appears at the tail.
REQ-041 Reset asserted during HOLD -> RD=0 immediately, Count=0, FSM=IDLE.
REQ-042 With UART_RXFIFO_PARITY_EN defined, character 8'h55 with RxParityErr=1 -> DoutParErr=1 at head; without the macro -> DoutParErr=0.
